seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_if.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 68 ++++++
 tb/tb_seg7_scan_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/seg7_if.sv
// seg7_if: data, mask and brightness inputs plus active-low pin outputs of the 7-segment scanner
interface seg7_if #(parameter int NUM_DIGITS = 8);
  logic disp_mode;
  logic load;
  logic [8*NUM_DIGITS-1:0] i_data;
  logic [NUM_DIGITS-1:0] i_dp;
  logic [NUM_DIGITS-1:0] i_blank;
  logic [NUM_DIGITS-1:0] i_blink;
  logic [3:0] i_bright;
  logic [7:0] disp_seg_o;
  logic [NUM_DIGITS-1:0] disp_an_o;
  modport master(output disp_mode, load, i_data, i_dp, i_blank, i_blink, i_bright, input disp_seg_o, disp_an_o);
  modport slave(input disp_mode, load, i_data, i_dp, i_blank, i_blink, i_bright, output disp_seg_o, disp_an_o);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed active-low 7-segment scanner with shadowed data, masks, blink and PWM brightness
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV = 15,
  parameter int BLINK_DIV = 24
) (
  input logic clk,
  input logic rstn,
  seg7_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [SCAN_DIV-1:0] scan_cnt;
  logic [BLINK_DIV:0] blink_cnt;
  logic [IW-1:0] idx, idx_next;
  logic [8*NUM_DIGITS-1:0] sh_data;
  logic [NUM_DIGITS-1:0] sh_dp, sh_blank, sh_blink, an_q, an_next;
  logic sh_mode, loaded, lit, on;
  logic [3:0] phase;
  logic [7:0] seg_q, seg_next;
  logic [3:0] nib [NUM_DIGITS];
  logic [7:0] raw [NUM_DIGITS];
  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_slice
    assign nib[i] = sh_data[4*i +: 4];
    assign raw[i] = sh_data[8*i +: 8];
  end
  // loaded keeps the display dark after reset until real data has been captured
  always_comb begin
    phase = scan_cnt[SCAN_DIV-1 -: 4];
    idx_next = &scan_cnt ? (idx == IW'(NUM_DIGITS - 1) ? '0 : idx + IW'(1)) : idx;
    lit = bus.i_bright == 4'hF || phase < bus.i_bright;
    on = loaded && lit && !sh_blank[idx] && !(sh_blink[idx] && blink_cnt[BLINK_DIV]);
    seg_next = !on ? 8'hFF : sh_mode ? raw[idx] : {~sh_dp[idx], HEX[nib[idx]]};
    an_next = on ? ~(NUM_DIGITS'(1) << idx) : '1;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scan_cnt <= '0;
      blink_cnt <= '0;
      idx <= '0;
      sh_data <= '0;
      sh_dp <= '0;
      sh_blank <= '0;
      sh_blink <= '0;
      sh_mode <= 1'b0;
      loaded <= 1'b0;
      seg_q <= 8'hFF;
      an_q <= '1;
    end else begin
      scan_cnt <= scan_cnt + SCAN_DIV'(1);
      blink_cnt <= blink_cnt + (BLINK_DIV+1)'(1);
      idx <= idx_next;
      loaded <= loaded | bus.load;
      seg_q <= seg_next;
      an_q <= an_next;
      if (bus.load) begin
        sh_data <= bus.i_data;
        sh_dp <= bus.i_dp;
        sh_blank <= bus.i_blank;
        sh_blink <= bus.i_blink;
        sh_mode <= bus.disp_mode;
      end
    end
  end
  assign bus.disp_seg_o = seg_q;
  assign bus.disp_an_o = an_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed checks of an 8-digit (SCAN_DIV 6) and a 5-digit (SCAN_DIV 4) scanner
module tb_seg7_scan_ctrl;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int cyc;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  // cyc-1 equals the scan/blink counter value the sampled outputs were computed from
  always @(posedge clk or negedge rstn) if (!rstn) cyc <= 0; else cyc <= cyc + 1;
  seg7_if #(.NUM_DIGITS(8)) b8();
  seg7_if #(.NUM_DIGITS(5)) b5();
  seg7_scan_ctrl #(.NUM_DIGITS(8), .SCAN_DIV(6), .BLINK_DIV(9)) u8 (.clk(clk), .rstn(rstn), .bus(b8.slave));
  seg7_scan_ctrl #(.NUM_DIGITS(5), .SCAN_DIV(4), .BLINK_DIV(6)) u5 (.clk(clk), .rstn(rstn), .bus(b5.slave));

  task automatic wait_c(input int t);
    int k = 0;
    while (cyc - 1 < t && k < 4000) begin
      @(negedge clk);
      k++;
    end
    if (cyc - 1 != t) begin
      $display("FAIL wait_c got %0d exp %0d", cyc - 1, t);
      errors++;
    end
  endtask

  task automatic do_reset;
    @(negedge clk) rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
  endtask

  task automatic load8(input logic [63:0] d, input logic m, input logic [7:0] dp, bl, bk);
    @(negedge clk);
    b8.i_data = d;
    b8.disp_mode = m;
    b8.i_dp = dp;
    b8.i_blank = bl;
    b8.i_blink = bk;
    b8.load = 1'b1;
    @(negedge clk) b8.load = 1'b0;
  endtask

  task automatic load5(input logic [39:0] d);
    @(negedge clk);
    b5.i_data = d;
    b5.load = 1'b1;
    @(negedge clk) b5.load = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    if ({b8.disp_seg_o, b8.disp_an_o} !== 16'hFFFF) begin
      $display("FAIL reset8 got %h exp FFFF", {b8.disp_seg_o, b8.disp_an_o}); errors++;
    end
    checks++;
    if ({b5.disp_seg_o, b5.disp_an_o} !== 13'h1FFF) begin
      $display("FAIL reset5 got %h exp 1FFF", {b5.disp_seg_o, b5.disp_an_o}); errors++;
    end
    checks++;
    rstn = 1'b1;
    wait_c(20);
    if ({b8.disp_seg_o, b8.disp_an_o} !== 16'hFFFF) begin
      $display("FAIL dark_before_load8 got %h exp FFFF", {b8.disp_seg_o, b8.disp_an_o}); errors++;
    end
    checks++;
    if ({b5.disp_seg_o, b5.disp_an_o} !== 13'h1FFF) begin
      $display("FAIL dark_before_load5 got %h exp 1FFF", {b5.disp_seg_o, b5.disp_an_o}); errors++;
    end
    checks++;
  endtask

  task automatic test_hex;
    int t [6] = '{10, 63, 64, 200, 458, 512};
    logic [15:0] e [6] = '{16'h8EFE, 16'h8EFE, 16'h86FD, 16'hC6F7, 16'h807F, 16'h8EFE};
    do_reset;
    b8.i_bright = 4'hF;
    load8(64'h89AB_CDEF, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      wait_c(t[i]);
      if ({b8.disp_seg_o, b8.disp_an_o} !== e[i]) begin
        $display("FAIL hex c=%0d got %h exp %h", t[i], {b8.disp_seg_o, b8.disp_an_o}, e[i]); errors++;
      end
      checks++;
    end
  endtask

  task automatic test_wrap;
    logic [7:0] es [6] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'hF9};
    logic [4:0] ea [6] = '{5'h1E, 5'h1D, 5'h1B, 5'h17, 5'h0F, 5'h1E};
    do_reset;
    b5.i_bright = 4'hF;
    b5.disp_mode = 1'b0;
    b5.i_dp = '0;
    b5.i_blank = '0;
    b5.i_blink = '0;
    load5(40'h54321);
    for (int k = 0; k < 6; k++) begin
      for (int o = 8; o < 16; o += 7) begin
        wait_c(16 * k + o);
        if ({b5.disp_seg_o, b5.disp_an_o} !== {es[k], ea[k]}) begin
          $display("FAIL wrap5 c=%0d got %h/%h exp %h/%h", 16 * k + o, b5.disp_seg_o, b5.disp_an_o, es[k], ea[k]); errors++;
        end
        checks++;
      end
    end
  endtask

  task automatic test_graph;
    do_reset;
    b8.i_bright = 4'hF;
    load8(64'h0000_0000_007F_0000, 1'b1, 8'hFF, 8'h00, 8'h00);
    wait_c(10);
    if ({b8.disp_seg_o, b8.disp_an_o} !== 16'h00FE) begin
      $display("FAIL graph_d0 got %h exp 00FE", {b8.disp_seg_o, b8.disp_an_o}); errors++;
    end
    checks++;
    wait_c(138);
    if ({b8.disp_seg_o, b8.disp_an_o} !== 16'h7FFB) begin
      $display("FAIL graph_d2 got %h exp 7FFB", {b8.disp_seg_o, b8.disp_an_o}); errors++;
    end
    checks++;
    load8(64'h0, 1'b0, 8'h01, 8'h00, 8'h00);
    wait_c(522);
    if ({b8.disp_seg_o, b8.disp_an_o} !== 16'h40FE) begin
      $display("FAIL text_dp got %h exp 40FE", {b8.disp_seg_o, b8.disp_an_o}); errors++;
    end
    checks++;
  endtask

  task automatic test_bright;
    int t [4] = '{64, 79, 80, 127};
    logic [15:0] e [4] = '{16'h86FD, 16'h86FD, 16'hFFFF, 16'hFFFF};
    do_reset;
    b8.i_bright = 4'd4;
    load8(64'h89AB_CDEF, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 4; i++) begin
      wait_c(t[i]);
      if ({b8.disp_seg_o, b8.disp_an_o} !== e[i]) begin
        $display("FAIL bright4 c=%0d got %h exp %h", t[i], {b8.disp_seg_o, b8.disp_an_o}, e[i]); errors++;
      end
      checks++;
    end
    b8.i_bright = 4'd0;
    for (int c = 128; c < 141; c += 12) begin
      wait_c(c);
      if ({b8.disp_seg_o, b8.disp_an_o} !== 16'hFFFF) begin
        $display("FAIL bright0 c=%0d got %h exp FFFF", c, {b8.disp_seg_o, b8.disp_an_o}); errors++;
      end
      checks++;
    end
  endtask

  task automatic test_blank_blink;
    int t [7] = '{10, 74, 522, 586, 650, 1098, 1162};
    logic [15:0] e [7] = '{16'hFFFF, 16'h86FD, 16'hFFFF, 16'hFFFF, 16'hA1FB, 16'h86FD, 16'hA1FB};
    do_reset;
    b8.i_bright = 4'hF;
    load8(64'h89AB_CDEF, 1'b0, 8'h00, 8'h01, 8'h02);
    for (int i = 0; i < 7; i++) begin
      wait_c(t[i]);
      if ({b8.disp_seg_o, b8.disp_an_o} !== e[i]) begin
        $display("FAIL mask c=%0d got %h exp %h", t[i], {b8.disp_seg_o, b8.disp_an_o}, e[i]); errors++;
      end
      checks++;
      if (i == 4) begin
        b8.i_data = '0;
        b8.i_blank = 8'hFF;
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    b8.i_bright = 4'hF;
    load8(64'h89AB_CDEF, 1'b0, 8'h00, 8'h00, 8'h00);
    wait_c(212);
    if ({b8.disp_seg_o, b8.disp_an_o} !== 16'hC6F7) begin
      $display("FAIL pre_reset got %h exp C6F7", {b8.disp_seg_o, b8.disp_an_o}); errors++;
    end
    checks++;
    #2 rstn = 1'b0;
    #1;
    if ({b8.disp_seg_o, b8.disp_an_o} !== 16'hFFFF) begin
      $display("FAIL async_reset got %h exp FFFF", {b8.disp_seg_o, b8.disp_an_o}); errors++;
    end
    checks++;
    @(negedge clk) rstn = 1'b1;
    wait_c(20);
    if ({b8.disp_seg_o, b8.disp_an_o} !== 16'hFFFF) begin
      $display("FAIL post_reset_dark got %h exp FFFF", {b8.disp_seg_o, b8.disp_an_o}); errors++;
    end
    checks++;
    load8(64'h89AB_CDEF, 1'b0, 8'h00, 8'h00, 8'h00);
    wait_c(40);
    if ({b8.disp_seg_o, b8.disp_an_o} !== 16'h8EFE) begin
      $display("FAIL restart_d0 got %h exp 8EFE", {b8.disp_seg_o, b8.disp_an_o}); errors++;
    end
    checks++;
  endtask

  initial begin
    b8.disp_mode = 1'b0; b8.load = 1'b0; b8.i_data = '0; b8.i_dp = '0;
    b8.i_blank = '0; b8.i_blink = '0; b8.i_bright = '0;
    b5.disp_mode = 1'b0; b5.load = 1'b0; b5.i_data = '0; b5.i_dp = '0;
    b5.i_blank = '0; b5.i_blink = '0; b5.i_bright = '0;
    test_reset;
    test_hex;
    test_wrap;
    test_graph;
    test_bright;
    test_blank_blink;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
